// File: rtl/aib_cfg_pkg.sv
// Shared types and default table for the AIB Avalon-MM config writer.
// Per-project tables replace CFG_TABLE_DEFAULT only.
package aib_cfg_pkg;

  localparam int AVMM_WIDTH    = 32;
  localparam int BYTE_WIDTH    = 4;
  localparam int AVMM_ADDR_W   = 17;
  localparam int CFG_TABLE_LEN = 8;

  typedef struct packed {
    logic [16:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        verify;
  } cfg_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_READ,
    ST_WAIT_RDATA,
    ST_DONE,
    ST_ERR
  } cfg_wr_state_t;

  localparam cfg_entry_t CFG_TABLE_DEFAULT [CFG_TABLE_LEN] = '{
    '{17'h0_0100, 32'h0000_0001, 4'hF, 1'b0},
    '{17'h0_0104, 32'hDEAD_BEEF, 4'hF, 1'b0},
    '{17'h0_0208, 32'hA5A5_00FF, 4'h3, 1'b1},
    '{17'h1_0010, 32'h1357_9BDF, 4'hF, 1'b1},
    '{17'h0_0300, 32'h0000_FF00, 4'h2, 1'b1},
    '{17'h0_0304, 32'h8000_0000, 4'h8, 1'b0},
    '{17'h1_FFFC, 32'h0F0F_0F0F, 4'h5, 1'b1},
    '{17'h0_0000, 32'hFFFF_FFFF, 4'hF, 1'b0}
  };

  function automatic logic [31:0] be_mask(
    input logic [3:0] be
  );
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < BYTE_WIDTH; i++)
      m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/aib_cfg_rom.sv
// Combinational config table lookup; out-of-range
// indices return an all-zero entry.
module aib_cfg_rom
  import aib_cfg_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] idx,
  output cfg_entry_t       entry
);

  always_comb begin
    entry = '0;
    for (int i = 0; i < CFG_TABLE_LEN; i++)
      if (int'(idx) == i)
        entry = CFG_TABLE_DEFAULT[i];
  end

endmodule

// File: rtl/aib_avmm_cfg_writer.sv
// Table-driven Avalon-MM config master: writes each table
// entry, optionally reads it back, then reports done/err.
module aib_avmm_cfg_writer
  import aib_cfg_pkg::*;
#(
  parameter  int NUM_ENTRIES    = 8,
  parameter  int VERIFY_EN      = 1,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W =
    (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_main_op,
  output logic             main_op_done,
  output logic             main_op_err,
  output logic [IDX_W-1:0] err_index,
  output logic [16:0]      avmm_address,
  output logic [31:0]      avmm_writedata,
  output logic [3:0]       avmm_byteenable,
  output logic             avmm_write,
  output logic             avmm_read,
  input  logic [31:0]      avmm_readdata,
  input  logic             avmm_readdatavalid,
  input  logic             avmm_waitrequest
);

  localparam int CNT_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_ENTRIES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  cfg_wr_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cfg_entry_t       ent_q, ent_d;
  cfg_entry_t       rom_entry;

  logic             last;
  logic             tmo;
  logic             rd_bad;
  cfg_wr_state_t    adv_st;
  logic [IDX_W-1:0] adv_idx;

  aib_cfg_rom #(
    .IDX_W (IDX_W)
  ) u_rom (
    .idx   (idx_q),
    .entry (rom_entry)
  );

  assign last    = (idx_q == LAST_IDX);
  assign tmo     = (cnt_q == TMO_LAST);
  assign adv_st  = last ? ST_DONE : ST_LOAD;
  assign adv_idx = last ? idx_q : idx_q + 1'b1;
  assign rd_bad  =
    |((avmm_readdata ^ ent_q.data) & be_mask(ent_q.be));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_idx_d = err_idx_q;
    cnt_d     = cnt_q;
    ent_d     = ent_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_main_op) begin
          state_d   = ST_LOAD;
          idx_d     = '0;
          err_idx_d = '0;
        end
      end
      ST_LOAD: begin
        ent_d   = rom_entry;
        cnt_d   = '0;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (!avmm_waitrequest) begin
          cnt_d = '0;
          if (VERIFY_EN != 0 && ent_q.verify) begin
            state_d = ST_READ;
          end else begin
            state_d = adv_st;
            idx_d   = adv_idx;
          end
        end else if (tmo) begin
          state_d   = ST_ERR;
          err_idx_d = idx_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READ: begin
        if (!avmm_waitrequest) begin
          cnt_d   = '0;
          state_d = ST_WAIT_RDATA;
        end else if (tmo) begin
          state_d   = ST_ERR;
          err_idx_d = idx_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_RDATA: begin
        if (avmm_readdatavalid) begin
          cnt_d = '0;
          if (rd_bad) begin
            state_d   = ST_ERR;
            err_idx_d = idx_q;
          end else begin
            state_d = adv_st;
            idx_d   = adv_idx;
          end
        end else if (tmo) begin
          state_d   = ST_ERR;
          err_idx_d = idx_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE, ST_ERR: begin
        if (!start_main_op)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      err_idx_q <= '0;
      cnt_q     <= '0;
      ent_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_idx_q <= err_idx_d;
      cnt_q     <= cnt_d;
      ent_q     <= ent_d;
    end
  end

  assign avmm_write      = (state_q == ST_WRITE);
  assign avmm_read       = (state_q == ST_READ);
  assign main_op_done    = (state_q == ST_DONE) ||
                           (state_q == ST_ERR);
  assign main_op_err     = (state_q == ST_ERR);
  assign err_index       = err_idx_q;
  assign avmm_address    = ent_q.addr;
  assign avmm_writedata  = ent_q.data;
  assign avmm_byteenable = ent_q.be;

endmodule

// File: tb/tb_aib_avmm_cfg_writer.sv
// Bench for aib_avmm_cfg_writer: random slave timing and
// readback against a transaction-level sequence model.
module tb_aib_avmm_cfg_writer;
  import aib_cfg_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        done, err;
  logic [1:0]  eidx;
  logic [16:0] addr;
  logic [31:0] wdata, rdata;
  logic [3:0]  be;
  logic        wr, rd, rdv, wreq;

  always #5 clk = ~clk;

  aib_avmm_cfg_writer #(
    .NUM_ENTRIES    (N),
    .VERIFY_EN      (1),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start_main_op      (start),
    .main_op_done       (done),
    .main_op_err        (err),
    .err_index          (eidx),
    .avmm_address       (addr),
    .avmm_writedata     (wdata),
    .avmm_byteenable    (be),
    .avmm_write         (wr),
    .avmm_read          (rd),
    .avmm_readdata      (rdata),
    .avmm_readdatavalid (rdv),
    .avmm_waitrequest   (wreq)
  );

  typedef struct {
    logic        is_rd;
    logic [16:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } beat_t;

  beat_t       exp_q[$];
  int          ws_pl[16];
  int          lat_pl[16];
  logic [31:0] rd_pl[16];
  int          exp_done, exp_err, exp_idx;

  int          pw[8], pr[8], pl[8];
  logic [31:0] pv[8];

  int          errs = 0;
  int          checks = 0;

  bit          running = 0;
  int          cyc, b, stall, pend;
  logic [31:0] pend_val;
  logic        p_wr, p_rd, p_wt;
  logic [16:0] p_a;
  logic [31:0] p_d;
  logic [3:0]  p_be;
  int          done_cyc;
  logic        done_err;
  logic [1:0]  done_idx;
  logic [1:0]  done_cmd;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] lane_mask(
    input logic [3:0] bev
  );
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++)
      if (bev[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  // Sequence model: cycle count, beat list and outcome.
  task automatic build_model();
    int c, bt;
    cfg_entry_t e;
    c = 0;
    bt = 0;
    exp_q.delete();
    exp_err = 0;
    exp_idx = 0;
    for (int i = 0; i < 16; i++) begin
      ws_pl[i] = 0;
      lat_pl[i] = 1;
      rd_pl[i] = '0;
    end
    for (int k = 0; k < N; k++) begin
      e = CFG_TABLE_DEFAULT[k];
      c += 1;
      ws_pl[bt] = pw[k];
      if (pw[k] >= TMO) begin
        c += TMO; exp_err = 1; exp_idx = k; break;
      end
      c += pw[k] + 1;
      exp_q.push_back('{1'b0, e.addr, e.data, e.be});
      bt++;
      if (e.verify) begin
        ws_pl[bt] = pr[k];
        lat_pl[bt] = pl[k];
        rd_pl[bt] = pv[k];
        if (pr[k] >= TMO) begin
          c += TMO; exp_err = 1; exp_idx = k; break;
        end
        c += pr[k] + 1 + pl[k];
        exp_q.push_back('{1'b1, e.addr, e.data, e.be});
        bt++;
        if (((pv[k] ^ e.data) & lane_mask(e.be)) != 0) begin
          exp_err = 1; exp_idx = k; break;
        end
      end
    end
    exp_done = c + 1;
  endtask

  task automatic clean_plan();
    for (int k = 0; k < 8; k++) begin
      pw[k] = 0;
      pr[k] = 0;
      pl[k] = 2;
      pv[k] = CFG_TABLE_DEFAULT[k].data;
    end
  endtask

  task automatic rand_plan();
    logic [31:0] x, m, d;
    for (int k = 0; k < 8; k++) begin
      pw[k] = ($urandom_range(0, 19) == 0) ? 20 : $urandom_range(0, 3);
      pr[k] = ($urandom_range(0, 19) == 0) ? 20 : $urandom_range(0, 3);
      pl[k] = $urandom_range(1, 4);
      x = $urandom;
      d = CFG_TABLE_DEFAULT[k].data;
      m = lane_mask(CFG_TABLE_DEFAULT[k].be);
      case ($urandom_range(0, 3))
        0:       pv[k] = d ^ x;
        1, 2:    pv[k] = d ^ (x & ~m);
        default: pv[k] = d;
      endcase
    end
  endtask

  // One clock of the Avalon slave, sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (running) begin
      cyc++;
      if ((p_wr || p_rd) && !p_wt) begin
        if (b < exp_q.size()) begin
          chk("beat_kind", p_rd, exp_q[b].is_rd);
          chk("beat_addr", p_a, exp_q[b].a);
          chk("beat_be", p_be, exp_q[b].be);
          if (p_wr) chk("beat_data", p_d, exp_q[b].d);
          if (p_rd) begin
            pend = lat_pl[b];
            pend_val = rd_pl[b];
          end
        end else begin
          chk("extra_beat", b, exp_q.size());
        end
        b++;
        stall = 0;
      end else if (p_wr || p_rd) begin
        stall++;
        chk("hold_addr", addr, p_a);
        chk("hold_data", wdata, p_d);
        chk("hold_be", be, p_be);
        if (!done) chk("hold_cmd", {wr, rd}, {p_wr, p_rd});
      end
      if (done && done_cyc == 0) begin
        done_cyc = cyc;
        done_err = err;
        done_idx = eidx;
        done_cmd = {wr, rd};
      end
      chk("wr_rd_excl", wr & rd, 0);
    end
    if (pend > 0) begin
      pend--;
      rdv = (pend == 0);
      rdata = rdv ? pend_val : $urandom;
    end else begin
      rdv = ($urandom_range(0, 3) == 0);
      rdata = $urandom;
    end
    if (wr || rd)
      wreq = (b < 16) ? (stall < ws_pl[b]) : 1'b0;
    else
      wreq = 1'($urandom_range(0, 1));
    p_wr = wr;
    p_rd = rd;
    p_wt = wreq;
    p_a = addr;
    p_d = wdata;
    p_be = be;
  endtask

  task automatic begin_run(input bit rel);
    build_model();
    b = 0;
    stall = 0;
    pend = 0;
    cyc = 0;
    done_cyc = 0;
    p_wr = 0;
    p_rd = 0;
    if (rel) rst_n = 1'b1;
    start = 1'b1;
    running = 1;
  endtask

  task automatic run_seq(input int hold, input bit drop,
                         input bit rel);
    int cnt;
    begin_run(rel);
    for (int i = 0; i < 600 && done_cyc == 0; i++) begin
      tick();
      if (drop && i == 2) start = 1'b0;
    end
    if (done_cyc == 0) begin
      chk("done_seen", 0, 1);
      running = 0;
      start = 1'b0;
      return;
    end
    chk("done_cycle", done_cyc, exp_done);
    chk("err_flag", done_err, exp_err);
    if (exp_err != 0) chk("err_index", done_idx, exp_idx);
    chk("cmd_in_done", done_cmd, 0);
    chk("beat_count", b, exp_q.size());
    cnt = 1;
    if (!drop) begin
      repeat (hold) begin
        tick();
        if (done) cnt++;
      end
      start = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) cnt++;
      else break;
    end
    chk("done_len", cnt, drop ? 1 : hold + 1);
    chk("idle_after", done, 0);
    running = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_eidx"}, eidx, 0);
    chk({tag, "_wr"}, wr, 0);
    chk({tag, "_rd"}, rd, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_be"}, be, 0);
  endtask

  task automatic reset_mid_read();
    bit found;
    clean_plan();
    begin_run(0);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (rd && addr == CFG_TABLE_DEFAULT[3].addr) found = 1;
    end
    chk("reach_read3", found, 1);
    #1 rst_n = 1'b0;
    running = 0;
    #1 chk_zero("async_rst");
    tick();
    tick();
    clean_plan();
    run_seq(1, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    rdv = 1'b0;
    rdata = '0;
    wreq = 1'b0;
    pend = 0;
    b = 0;
    stall = 0;
    repeat (3) tick();
    #1 chk_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    clean_plan();
    run_seq(2, 0, 0);

    clean_plan();
    pw[1] = 3;
    run_seq(0, 0, 0);

    clean_plan();
    pv[2] = 32'h1234_00FF;
    run_seq(1, 0, 0);

    clean_plan();
    pv[2] = 32'hA5A5_01FF;
    run_seq(0, 0, 0);

    clean_plan();
    pw[0] = 20;
    run_seq(1, 0, 0);

    clean_plan();
    pr[3] = 20;
    run_seq(0, 0, 0);

    clean_plan();
    pl[3] = 1;
    run_seq(0, 1, 0);

    reset_mid_read();

    for (int r = 0; r < 40; r++) begin
      rand_plan();
      run_seq($urandom_range(0, 2),
              $urandom_range(0, 4) == 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
